// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the buffered 1-to-4 demultiplexer.
//   WIDTH      data width of every lane
//   SEL_WIDTH  lane select width
//   NUM_LANES  number of output lanes (1 << SEL_WIDTH)
//   DEPTH      entries per lane buffer (head register + one storage entry)
//   lane_idx_t lane index type
//   level_t    per-lane occupancy type (0..DEPTH)
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int WIDTH     = 16;
    localparam int SEL_WIDTH = 2;
    localparam int NUM_LANES = 1 << SEL_WIDTH;
    localparam int DEPTH     = 2;

    typedef logic [SEL_WIDTH-1:0] lane_idx_t;
    typedef logic [1:0]           level_t;

endpackage : demux_pkg

// File: rtl/demux_lane_fifo.sv
// -----------------------------------------------------------------------------
// demux_lane_fifo
// Two-entry lane FIFO: a registered head word plus one storage entry.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored when full)
//   push_data    word to write
//   pop          consumer accepts head (ignored when empty)
//   head         current head word, registered; holds its value when empty
//   valid        head valid (level != 0)
//   level        occupancy 0..2
// -----------------------------------------------------------------------------
module demux_lane_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = demux_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output level_t           level
);

    logic [WIDTH-1:0] tail_q;
    level_t           level_q;
    logic             do_push;
    logic             do_pop;

    // Guard locally so the FIFO can never over- or under-run, whatever the caller does.
    assign do_push = push && (level_q != level_t'(DEPTH));
    assign do_pop  = pop  && (level_q != level_t'(0));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    // NOTE: the storage entry is reset along with the head; it is a single word,
    // so clearing it costs nothing and keeps the state fully defined after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else if (do_push && do_pop) begin
            // Only reachable at level 1: the new word replaces the departing head.
            head <= push_data;
        end else if (do_push) begin
            if (level_q == level_t'(0)) begin
                head <= push_data;
            end else begin
                tail_q <= push_data;
            end
            level_q <= level_q + level_t'(1);
        end else if (do_pop) begin
            // At level 1 the head simply goes stale; it is not cleared.
            if (level_q == level_t'(DEPTH)) begin
                head <= tail_q;
            end
            level_q <= level_q - level_t'(1);
        end
    end

    assign valid = (level_q != level_t'(0));
    assign level = level_q;

endmodule : demux_lane_fifo

// File: rtl/demux_1to4_16bit.sv
// -----------------------------------------------------------------------------
// demux_1to4_16bit
// Buffered 1-to-4 demultiplexer: one valid/ready stream is steered word by word
// to one of four lanes, each with its own 2-entry FIFO so a stalled consumer
// never blocks or reorders traffic to the others.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_sel/in_valid input word, destination lane, word present
//   in_ready               selected lane has room (no path from out_ready)
//   out_data0..3           head word of each lane, registered
//   out_valid[i]           lane i head valid
//   out_ready[i]           consumer i accepts head
//   lane_level             occupancy, lane i at [2i+1:2i]
// -----------------------------------------------------------------------------
module demux_1to4_16bit
    import demux_pkg::*;
#(
    parameter int WIDTH     = demux_pkg::WIDTH,
    parameter int SEL_WIDTH = demux_pkg::SEL_WIDTH,
    parameter int DEPTH     = demux_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_WIDTH-1:0]   in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data0,
    output logic [WIDTH-1:0]       out_data1,
    output logic [WIDTH-1:0]       out_data2,
    output logic [WIDTH-1:0]       out_data3,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [7:0]             lane_level
);

    localparam int LANES = 1 << SEL_WIDTH;

    logic [LANES-1:0] push_en;
    level_t           levels [LANES];
    logic [WIDTH-1:0] heads  [LANES];

    // Gated with rst_n so the source sees "not ready" for the whole reset window.
    assign in_ready = rst_n && (levels[in_sel] != level_t'(DEPTH));

    // NOTE: every always_comb output gets a default first; otherwise the
    // paths that skip the assignment would infer a latch.
    always_comb begin
        push_en = '0;
        if (in_valid && in_ready) begin
            push_en[in_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane_fifo #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_en[i]),
            .push_data (in_data),
            .pop       (out_ready[i]),
            .head      (heads[i]),
            .valid     (out_valid[i]),
            .level     (levels[i])
        );

        assign lane_level[2*i +: 2] = levels[i];
    end

    assign out_data0 = heads[0];
    assign out_data1 = heads[1];
    assign out_data2 = heads[2];
    assign out_data3 = heads[3];

endmodule : demux_1to4_16bit

// File: tb/tb_demux_1to4_16bit.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4_16bit
// Self-checking bench: per-lane reference queues act as the scoreboard; words
// are pushed when the bench drives an accepted transfer and popped when the
// consumer takes them. A vector table covers streaming and back-pressure; short
// hand-written sequences cover same-cycle push/pop, draining and mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_demux_1to4_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [7:0]  lane_level;

    always #5 clk = ~clk;

    demux_1to4_16bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lane_level (lane_level)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  ordy;
        logic        exp_rdy;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] mdl_q[4][$];
    logic [15:0] last_head[4];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] dut_data(input int i);
        case (i)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mdl_q[i].delete();
            last_head[i] = '0;
        end
    endtask

    task automatic check_lanes();
        for (int i = 0; i < 4; i++) begin
            int          sz;
            logic [15:0] exp_d;
            sz    = mdl_q[i].size();
            exp_d = (sz != 0) ? mdl_q[i][0] : last_head[i];
            check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(sz != 0));
            check($sformatf("lane_level[%0d]", i), 32'(lane_level[2*i +: 2]), 32'(sz));
            check($sformatf("out_data%0d", i), 32'(dut_data(i)), 32'(exp_d));
        end
    endtask

    // Called just after a falling edge: drive, check, advance the model, clock once.
    task automatic step(input logic v, input logic [1:0] sel, input logic [15:0] d,
                        input logic [3:0] ordy, output logic rdy_seen);
        logic exp_rdy;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy  = (mdl_q[sel].size() != 2);
        rdy_seen = in_ready;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_lanes();
        for (int i = 0; i < 4; i++) begin
            if (ordy[i] && mdl_q[i].size() != 0) begin
                last_head[i] = mdl_q[i][0];
                void'(mdl_q[i].pop_front());
            end
        end
        if (v && exp_rdy) mdl_q[sel].push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic r;

        model_reset();
        // Reset state, with a word offered so in_ready must be held low by reset.
        in_valid = 1'b1;
        in_sel   = 2'd1;
        @(negedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset lane_level", 32'(lane_level), 32'h0);
        check_lanes();
        rst_n = 1'b1;

        // Streaming across all lanes, then back-pressure on lane 2.
        vecs.push_back('{1'b1, 2'd0, 16'h1111, 4'hF, 1'b1});
        vecs.push_back('{1'b1, 2'd1, 16'h2222, 4'hF, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 16'h3333, 4'hF, 1'b1});
        vecs.push_back('{1'b1, 2'd3, 16'h4444, 4'hF, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 16'hA001, 4'hB, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 16'hA002, 4'hB, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 16'hA003, 4'hB, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 16'hA003, 4'hB, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1});
        vecs.push_back('{1'b0, 2'd2, 16'h0000, 4'hF, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1});
        foreach (vecs[k]) begin
            step(vecs[k].v, vecs[k].sel, vecs[k].data, vecs[k].ordy, r);
            check($sformatf("vec%0d in_ready", k), 32'(r), 32'(vecs[k].exp_rdy));
        end

        // Same-cycle push and pop on lane 1 at level 1.
        step(1'b1, 2'd1, 16'hB001, 4'b0000, r);
        step(1'b1, 2'd1, 16'hB002, 4'b0010, r);
        check("pushpop in_ready", 32'(r), 32'h1);
        check("pushpop level1", 32'(lane_level[3:2]), 32'h1);
        check("pushpop data1", 32'(out_data1), 32'hB002);
        step(1'b0, 2'd0, 16'h0000, 4'b0010, r);

        // Lane 3 full, then drained in order.
        step(1'b1, 2'd3, 16'hC001, 4'b0000, r);
        step(1'b1, 2'd3, 16'hC002, 4'b0000, r);
        check("full level3", 32'(lane_level[7:6]), 32'h2);
        check("full head3", 32'(out_data3), 32'hC001);
        step(1'b0, 2'd3, 16'h0000, 4'b1000, r);
        check("pop1 head3", 32'(out_data3), 32'hC002);
        check("pop1 level3", 32'(lane_level[7:6]), 32'h1);
        step(1'b0, 2'd3, 16'h0000, 4'b1000, r);
        check("pop2 valid3", 32'(out_valid[3]), 32'h0);
        check("pop2 hold3", 32'(out_data3), 32'hC002);

        // Fill lanes 0 and 2, then reset in the middle of a cycle.
        step(1'b1, 2'd0, 16'hE001, 4'b0000, r);
        step(1'b1, 2'd0, 16'hE002, 4'b0000, r);
        step(1'b1, 2'd2, 16'hE003, 4'b0000, r);
        step(1'b1, 2'd2, 16'hE004, 4'b0000, r);
        check("prefill level", 32'(lane_level), 32'h22);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 16'hE005;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst in_ready", 32'(in_ready), 32'h0);
        check("midrst out_valid", 32'(out_valid), 32'h0);
        check("midrst lane_level", 32'(lane_level), 32'h0);
        check_lanes();
        @(posedge clk);
        @(negedge clk);
        check("rsthold out_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        step(1'b1, 2'd2, 16'hD00D, 4'b0000, r);
        check("post-rst accept", 32'(r), 32'h1);
        check("post-rst data2", 32'(out_data2), 32'hD00D);
        check("post-rst valid", 32'(out_valid), 32'h4);
        step(1'b0, 2'd0, 16'h0000, 4'hF, r);
        step(1'b0, 2'd0, 16'h0000, 4'hF, r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux_1to4_16bit

// File: doc/demux_1to4_16bit.md
# demux_1to4_16bit

Buffered 1-to-4 demultiplexer: steers a single 16-bit valid/ready stream onto one of four output lanes chosen per word by a 2-bit select. It is the distribution end of the 4-to-1 lane-selection datapath: it fans one source out to four independent consumers. Each lane has a 2-entry buffer, so a stalled lane never corrupts or reorders traffic to the other lanes.

## Interface
Parameters:
- WIDTH, 16, data width of every lane
- SEL_WIDTH, 2, select width; lane count is 1<<SEL_WIDTH = 4
- DEPTH, 2, entries per lane buffer; fixed at 2 in this revision

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  input word
- in_sel  input  SEL_WIDTH  destination lane of in_data, qualified by in_valid
- in_valid  input  1  input word present
- in_ready  output  1  selected lane can accept; transfer when in_valid & in_ready
- out_data0..out_data3  output  WIDTH  head word of lane 0..3
- out_valid  output  4  bit i: lane i head valid
- out_ready  input  4  bit i: consumer i accepts; pop when out_valid[i] & out_ready[i]
- lane_level  output  8  2 bits per lane (lane i at [2i+1:2i]): occupancy 0..2

## Operation
- Each lane is an independent 2-entry FIFO: head register plus one storage entry, with a 2-bit occupancy count.
- in_ready = rst_n & (lane_level[in_sel] != 2). Combinational from in_sel and registered state only; no path from out_ready.
- Push: on input transfer, write in_data into lane in_sel. Other lanes are unaffected.
- Pop: lane i drops its head on out_valid[i] & out_ready[i]. Pops on all four lanes may occur in the same cycle as each other and as a push.
- Push and pop on the same lane in the same cycle, occupancy 1: level stays 1, new word becomes head. Occupancy 2: the push cannot occur (in_ready=0). Occupancy 0: the push lands, level becomes 1; no pop is possible.
- in_valid with a full lane: word held by source, no state change. The source may change in_sel while stalled; in_ready re-evaluates immediately.
- Order within a lane is strictly FIFO. No ordering between lanes.
- out_valid[i] = (level_i != 0). out_data_i = head, registered.

## Timing
- Latency: a word accepted in cycle N is visible on out_data_i with out_valid[i]=1 in cycle N+1.
- Throughput: 1 word/cycle when consumers keep up; a single lane sustains 1 word/cycle with out_ready held high.
- Reset (rst_n low, async, at any time including mid-transfer): all levels 0, out_valid=0, out_data0..3=0, lane_level=0, in_ready=0. Buffered words are discarded. First acceptance is possible in the first cycle after rst_n deasserts.
- out_data_i holds its last value when the lane empties. It is not cleared, and it is only meaningful when out_valid[i]=1.

## Structure
- Package demux_pkg: WIDTH, SEL_WIDTH, NUM_LANES constants; lane_idx_t (SEL_WIDTH bits); level_t (2 bits).
- Sub-module demux_lane_fifo: 2-entry FIFO with push/pop/level/head, async active-low reset. Instantiate it four times.
- Top level contains only the select decode (one-hot push enables), the in_ready mux and lane_level packing.

## Test plan
- Release reset, send 0x1111/sel0, 0x2222/sel1, 0x3333/sel2, 0x4444/sel3 back-to-back, all out_ready=1 -> each word appears on its lane exactly one cycle after acceptance, in_ready held 1 throughout.
- out_ready[2]=0, send 0xA001, 0xA002, 0xA003 to lane 2 -> first two accepted, lane_level[5:4]=2, in_ready=0 on the third. Switch in_sel to 0 -> in_ready=1 that same cycle.
- Lane 1 at level 1 (head 0xB001): simultaneous push 0xB002 and pop -> level stays 1, next cycle out_data1=0xB002.
- Lane 3 full (0xC001, 0xC002), then out_ready[3]=1 for 2 cycles -> pops 0xC001 then 0xC002 in order, out_valid[3] falls after the second pop.
- Fill lanes 0 and 2 to level 2, assert rst_n low mid-cycle -> out_valid=0, lane_level=0, out_data*=0 and in_ready=0 immediately. After release, 0xD00D/sel2 appears one cycle later.
